// File: rtl/except_commit_ctrl.sv
// ============================================================================
// Module   : except_commit_ctrl
// Purpose  : Sequences the commit of a mem-stage exception/ERET. It stalls the
//            pipeline, drains bus traffic, issues a one-cycle CP0 update and
//            flush, then holds a PC redirect until fetch accepts it.
// Options  : EXCEPT_DRAIN_WATCHDOG_EN enables the drain watchdog and the
//            drain_timeout output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module except_commit_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_eret,
    input  logic [4:0]        req_code,
    input  logic              req_delayslot,
    input  logic [ADDR_W-1:0] req_cur_pc,
    input  logic [ADDR_W-1:0] req_badvaddr,
    input  logic [ADDR_W-1:0] req_jump_pc,
    input  logic              status_exl,
    input  logic              status_erl,
    input  logic              mem_busy,
    input  logic              redirect_ready,
    output logic              stall_o,
    output logic              flush_o,
    output logic              cp0_epc_we,
    output logic [ADDR_W-1:0] cp0_epc,
    output logic              cp0_cause_we,
    output logic [4:0]        cp0_cause_code,
    output logic              cp0_cause_bd,
    output logic              cp0_badvaddr_we,
    output logic [ADDR_W-1:0] cp0_badvaddr,
    output logic              cp0_set_exl,
    output logic              cp0_clr_exl,
    output logic              cp0_clr_erl,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
`ifdef EXCEPT_DRAIN_WATCHDOG_EN
    ,
    output logic              drain_timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_eret;
    logic [4:0]        r_code;
    logic              r_ds;
    logic [ADDR_W-1:0] r_cur_pc;
    logic [ADDR_W-1:0] r_badvaddr;
    logic [ADDR_W-1:0] r_jump_pc;
    logic              r_exl;
    logic              r_erl;

    logic              w_wd_expire;
    logic              w_is_exc;
    logic              w_addr_code;

`ifdef EXCEPT_DRAIN_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]  r_wd_cnt;
    logic              r_wd_fired;

    // The count reads k-1 in the k-th DRAIN cycle, so expiry lands on cycle MAX_WAIT.
    assign w_wd_expire = (r_state == S_DRAIN) && mem_busy &&
                         (r_wd_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_wd_cnt   <= r_wd_cnt + 1'b1;
            r_wd_fired <= w_wd_expire;
        end
    end

    assign drain_timeout = (r_state == S_COMMIT) && r_wd_fired;
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request fields and CP0 status are captured once and frozen for the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eret     <= 1'b0;
            r_code     <= '0;
            r_ds       <= 1'b0;
            r_cur_pc   <= '0;
            r_badvaddr <= '0;
            r_jump_pc  <= '0;
            r_exl      <= 1'b0;
            r_erl      <= 1'b0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_eret     <= req_eret;
            r_code     <= req_code;
            r_ds       <= req_delayslot;
            r_cur_pc   <= req_cur_pc;
            r_badvaddr <= req_badvaddr;
            r_jump_pc  <= req_jump_pc;
            r_exl      <= status_exl;
            r_erl      <= status_erl;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = mem_busy ? S_DRAIN : S_COMMIT;
                end
            end
            S_DRAIN: begin
                if (!mem_busy || w_wd_expire) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_is_exc    = !r_eret;
    assign w_addr_code = (r_code != 5'd0) && (r_code <= 5'd5);

    always_comb begin
        stall_o         = 1'b1;
        busy            = 1'b1;
        flush_o         = 1'b0;
        cp0_epc_we      = 1'b0;
        cp0_epc         = '0;
        cp0_cause_we    = 1'b0;
        cp0_cause_code  = '0;
        cp0_cause_bd    = 1'b0;
        cp0_badvaddr_we = 1'b0;
        cp0_badvaddr    = '0;
        cp0_set_exl     = 1'b0;
        cp0_clr_exl     = 1'b0;
        cp0_clr_erl     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        case (r_state)
            S_IDLE: begin
                stall_o = req_valid;
                busy    = 1'b0;
            end
            S_COMMIT: begin
                flush_o = 1'b1;
                if (w_is_exc) begin
                    // Nested exceptions (EXL already set) leave EPC and BD untouched.
                    if (!r_exl) begin
                        cp0_epc_we   = 1'b1;
                        cp0_epc      = r_ds ? (r_cur_pc - ADDR_W'(4)) : r_cur_pc;
                        cp0_cause_bd = r_ds;
                    end
                    cp0_cause_we   = 1'b1;
                    cp0_cause_code = r_code;
                    cp0_set_exl    = 1'b1;
                    if (w_addr_code) begin
                        cp0_badvaddr_we = 1'b1;
                        cp0_badvaddr    = r_badvaddr;
                    end
                end else begin
                    cp0_clr_erl = r_erl;
                    cp0_clr_exl = !r_erl;
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_jump_pc;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_except_commit_ctrl.sv
// ============================================================================
// Module   : tb_except_commit_ctrl
// Purpose  : Directed and randomized checks of except_commit_ctrl against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_except_commit_ctrl;

    localparam int AW = 32;
    localparam int WD_MAX = 4;
`ifdef EXCEPT_DRAIN_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_eret, req_delayslot;
    logic [4:0]    req_code;
    logic [AW-1:0] req_cur_pc, req_badvaddr, req_jump_pc;
    logic          status_exl, status_erl, mem_busy, redirect_ready;
    logic          stall_o, flush_o, cp0_epc_we, cp0_cause_we, cp0_cause_bd;
    logic          cp0_badvaddr_we, cp0_set_exl, cp0_clr_exl, cp0_clr_erl;
    logic          redirect_valid, busy;
    logic [4:0]    cp0_cause_code;
    logic [AW-1:0] cp0_epc, cp0_badvaddr, redirect_pc;
    logic          drain_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    except_commit_ctrl #(.ADDR_W(AW), .MAX_WAIT(WD_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_eret(req_eret), .req_code(req_code),
        .req_delayslot(req_delayslot), .req_cur_pc(req_cur_pc),
        .req_badvaddr(req_badvaddr), .req_jump_pc(req_jump_pc),
        .status_exl(status_exl), .status_erl(status_erl),
        .mem_busy(mem_busy), .redirect_ready(redirect_ready),
        .stall_o(stall_o), .flush_o(flush_o),
        .cp0_epc_we(cp0_epc_we), .cp0_epc(cp0_epc),
        .cp0_cause_we(cp0_cause_we), .cp0_cause_code(cp0_cause_code),
        .cp0_cause_bd(cp0_cause_bd),
        .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
        .cp0_set_exl(cp0_set_exl), .cp0_clr_exl(cp0_clr_exl),
        .cp0_clr_erl(cp0_clr_erl),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
`ifdef EXCEPT_DRAIN_WATCHDOG_EN
        , .drain_timeout(drain_timeout)
`endif
    );

`ifndef EXCEPT_DRAIN_WATCHDOG_EN
    assign drain_timeout = 1'b0;
`endif

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".flush"},   flush_o, 0);
        chk({tag, ".epc_we"},  cp0_epc_we, 0);
        chk({tag, ".cause_we"}, cp0_cause_we, 0);
        chk({tag, ".bad_we"},  cp0_badvaddr_we, 0);
        chk({tag, ".set_exl"}, cp0_set_exl, 0);
        chk({tag, ".clr_exl"}, cp0_clr_exl, 0);
        chk({tag, ".clr_erl"}, cp0_clr_erl, 0);
    endtask

    // Inputs that the DUT must ignore mid-sequence are scrambled.
    task automatic scramble();
        req_eret       = 1'($urandom);
        req_code       = 5'($urandom);
        req_delayslot  = 1'($urandom);
        req_cur_pc     = $urandom;
        req_badvaddr   = $urandom;
        req_jump_pc    = $urandom;
        status_exl     = 1'($urandom);
        status_erl     = 1'($urandom);
    endtask

    // One full request: busy_len cycles of mem_busy starting at the request,
    // then fetch accepts the redirect after rdy_delay stalled cycles.
    task automatic run_txn(input bit eret, input logic [4:0] code, input bit ds,
                           input logic [AW-1:0] pc, input logic [AW-1:0] bva,
                           input logic [AW-1:0] jpc, input bit exl, input bit erl,
                           input int busy_len, input int rdy_delay);
        int  n_drain;
        bit  exp_to;
        bit  exc;
        logic [AW-1:0] exp_epc;
        exc     = !eret;
        exp_to  = WD_ON && (busy_len > WD_MAX);
        n_drain = exp_to ? WD_MAX : busy_len;
        exp_epc = ds ? pc - 32'd4 : pc;

        @(negedge clk);
        req_valid = 1'b1; req_eret = eret; req_code = code; req_delayslot = ds;
        req_cur_pc = pc; req_badvaddr = bva; req_jump_pc = jpc;
        status_exl = exl; status_erl = erl;
        mem_busy = (busy_len > 0); redirect_ready = 1'($urandom);
        #1;
        chk("req.stall", stall_o, 1);
        chk("req.busy", busy, 0);

        for (int k = 1; k <= n_drain; k++) begin
            @(negedge clk);
            scramble();
            mem_busy = (k < busy_len);
            redirect_ready = 1'($urandom);
            #1;
            chk("drain.stall", stall_o, 1);
            chk("drain.busy", busy, 1);
            chk("drain.rv", redirect_valid, 0);
            chk_quiet("drain");
        end

        @(negedge clk);
        scramble();
        mem_busy = 1'($urandom);
        redirect_ready = 1'($urandom);
        #1;
        chk("commit.flush", flush_o, 1);
        chk("commit.stall", stall_o, 1);
        chk("commit.rv", redirect_valid, 0);
        chk("commit.epc_we", cp0_epc_we, exc && !exl);
        if (exc && !exl) begin
            chk("commit.epc", cp0_epc, exp_epc);
            chk("commit.bd", cp0_cause_bd, ds);
        end
        chk("commit.cause_we", cp0_cause_we, exc);
        if (exc) chk("commit.code", cp0_cause_code, code);
        chk("commit.bad_we", cp0_badvaddr_we, exc && code >= 5'd1 && code <= 5'd5);
        if (exc && code >= 5'd1 && code <= 5'd5) chk("commit.bva", cp0_badvaddr, bva);
        chk("commit.set_exl", cp0_set_exl, exc);
        chk("commit.clr_erl", cp0_clr_erl, eret && erl);
        chk("commit.clr_exl", cp0_clr_exl, eret && !erl);
        chk("commit.timeout", drain_timeout, exp_to);

        for (int d = 0; d <= rdy_delay; d++) begin
            @(negedge clk);
            scramble();
            mem_busy = 1'($urandom);
            redirect_ready = (d == rdy_delay);
            #1;
            chk("redir.valid", redirect_valid, 1);
            chk("redir.pc", redirect_pc, jpc);
            chk("redir.stall", stall_o, 1);
            chk_quiet("redir");
        end

        @(negedge clk);
        req_valid = 1'b0;
        redirect_ready = 1'($urandom);
        #1;
        chk("done.rv", redirect_valid, 0);
        chk("done.stall", stall_o, 0);
        chk("done.busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_eret = 1'b0; req_code = '0;
        req_delayslot = 1'b0; req_cur_pc = '0; req_badvaddr = '0; req_jump_pc = '0;
        status_exl = 1'b0; status_erl = 1'b0; mem_busy = 1'b0; redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.stall", stall_o, 0);
        chk("rst.rv", redirect_valid, 0);
        chk_quiet("rst");

        // SYSCALL, no drain, immediate accept
        run_txn(1'b0, 5'd8, 1'b0, 32'h8000_1000, 32'h0, 32'h8000_0180, 1'b0, 1'b0, 0, 0);
        // ADEL in delay slot
        run_txn(1'b0, 5'd4, 1'b1, 32'h8000_2004, 32'h0000_0003, 32'h8000_0180, 1'b0, 1'b0, 0, 0);
        // five cycles of outstanding bus traffic (watchdog build caps the drain)
        run_txn(1'b0, 5'd2, 1'b0, 32'h8000_3000, 32'h1234_5678, 32'h8000_0180, 1'b0, 1'b0, 5, 1);
        // ERET with ERL set
        run_txn(1'b1, 5'd0, 1'b0, 32'h8000_4000, 32'h0, 32'hBFC0_0000, 1'b1, 1'b1, 0, 0);
        // ERET with only EXL set
        run_txn(1'b1, 5'd0, 1'b0, 32'h8000_4000, 32'h0, 32'h8000_5554, 1'b1, 1'b0, 2, 0);
        // nested interrupt with slow fetch
        run_txn(1'b0, 5'd0, 1'b1, 32'h8000_6000, 32'hFFFF_FFFF, 32'h8000_0180, 1'b1, 1'b0, 0, 3);
        // EPC wraps below zero
        run_txn(1'b0, 5'd5, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h8000_0180, 1'b0, 1'b0, 1, 0);

        // reset in the middle of a drain
        @(negedge clk);
        req_valid = 1'b1; req_eret = 1'b0; req_code = 5'd3; mem_busy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("mid.busy_before", busy, 1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_busy = 1'b0;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.stall", stall_o, 0);
        chk("mid.rv", redirect_valid, 0);
        chk_quiet("mid");

        // stuck bus: a watchdog build forces commit, otherwise the wait continues
        run_txn(1'b0, 5'd1, 1'b0, 32'h8000_7000, 32'h0000_7777, 32'h8000_0180, 1'b0, 1'b0, 9, 0);

        for (int t = 0; t < 60; t++) begin
            run_txn(($urandom_range(0, 3) == 0), 5'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
